even_counter_ctrl: RTL and testbench

Sequencer for the 8-bit even up-counter datapath: loads a start value, steps the count by +2 on each enabled clock, and stops (or reloads) at a programmable terminal value. Sits between the host control logic and the counter register, exposing a start/done handshake plus pause and clear controls. It replaces free-running counter use wherever a bounded, restartable even count is required.

---
 rtl/even_counter_pkg.sv | 6 +
 rtl/even_incr.sv | 17 +
 rtl/even_counter_ctrl.sv | 80 ++++++++
 tb/tb_even_counter_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/even_counter_pkg.sv
// even_counter_pkg: shared state encoding and constants for the even up-counter sequencer
package even_counter_pkg;
    localparam int STEP = 2;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
endpackage

// File: rtl/even_incr.sv
// even_incr: +2 ripple incrementer; bit 0 stays 0 and the chain carry-out flags the 254 -> 0 step
module even_incr #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:1] a,
    output logic [WIDTH-1:0] y,
    output logic             co
);
    logic [WIDTH:1] c;
    assign c[1] = 1'b1;
    assign y[0] = 1'b0;
    for (genvar i = 1; i < WIDTH; i++) begin : g_rip
        assign y[i]   = a[i] ^ c[i];
        assign c[i+1] = a[i] & c[i];
    end
    assign co = c[WIDTH];
endmodule

// File: rtl/even_counter_ctrl.sv
// even_counter_ctrl: start/stop sequencer for a bounded +2 even counter with pause and clear
// EVEN_COUNTER_CTRL_AUTO_RELOAD_EN: reload the start value at terminal and pulse done instead of stopping
module even_counter_ctrl
    import even_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] stop_val,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);
    state_t st;
    logic [WIDTH-1:0] hi, nxt, s_even;
    logic co;
`ifdef EVEN_COUNTER_CTRL_AUTO_RELOAD_EN
    logic [WIDTH-1:0] lo;
`endif
    assign s_even = start_val & ~WIDTH'(1);
    even_incr #(.WIDTH(WIDTH)) u_incr (
        .a  (q[WIDTH-1:1]),
        .y  (nxt),
        .co (co)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st   <= IDLE;
            q    <= '0;
            hi   <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            wrap <= 1'b0;
`ifdef EVEN_COUNTER_CTRL_AUTO_RELOAD_EN
            lo   <= '0;
`endif
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                st   <= IDLE;
                q    <= '0;
                busy <= 1'b0;
                done <= 1'b0;
            end else if ((st == IDLE || st == DONE) && start) begin
                st   <= RUN;
                q    <= s_even;
                hi   <= stop_val & ~WIDTH'(1);
                busy <= 1'b1;
                done <= 1'b0;
`ifdef EVEN_COUNTER_CTRL_AUTO_RELOAD_EN
                lo   <= s_even;
`endif
            end else if (st == RUN) begin
                // terminal check outranks pause so a paused terminal count still finishes
                done <= (q == hi);
                if (q == hi) begin
`ifdef EVEN_COUNTER_CTRL_AUTO_RELOAD_EN
                    q <= lo;
`else
                    st   <= DONE;
                    busy <= 1'b0;
`endif
                end else if (pause) begin
                    st <= HOLD;
                end else begin
                    q    <= nxt;
                    wrap <= co;
                end
            end else if (st == HOLD && !pause) begin
                st <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_even_counter_ctrl.sv
// tb_even_counter_ctrl: directed vector table, reset-mid-run sequence and randomized run against a reference model
module tb_even_counter_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [7:0] sv = 8'd0, tv = 8'd0;
    logic [7:0] q;
    logic busy, done, wrap;
    int checks = 0;
    int errors = 0;

    even_counter_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .clear     (clear),
        .start_val (sv),
        .stop_val  (tv),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    localparam int MI = 0, MR = 1, MH = 2, MD = 3;
    int mm;
    logic [7:0] mq, mlo, mhi;
    logic mb, md, mw;

    task automatic mreset();
        mm = MI; mq = 0; mlo = 0; mhi = 0; mb = 0; md = 0; mw = 0;
    endtask

    // reference: apply the edge priority list to the current inputs
    task automatic mstep();
        mw = 0;
        if (clear) begin
            mq = 0; mm = MI; md = 0; mb = 0;
        end else if ((mm == MI || mm == MD) && start) begin
            mlo = {sv[7:1], 1'b0}; mhi = {tv[7:1], 1'b0};
            mq = mlo; mm = MR; mb = 1; md = 0;
        end else if (mm == MR && mq == mhi) begin
            md = 1;
`ifdef EVEN_COUNTER_CTRL_AUTO_RELOAD_EN
            mq = mlo;
`else
            mm = MD; mb = 0;
`endif
        end else if (mm == MR && pause) begin
            mm = MH; md = 0;
        end else if (mm == MR) begin
            mw = (int'(mq) + 2 == 256);
            mq = 8'((int'(mq) + 2) % 256);
            md = 0;
        end else if (mm == MH && !pause) begin
            mm = MR;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        mstep();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic st, pa, cl;
        logic [7:0] s, t, eq;
        logic eb, ed, ew;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic st_i, pa_i, cl_i, input logic [7:0] s_i, t_i, eq_i,
                       input logic eb_i, ed_i, ew_i);
        vec_t v;
        v.st = st_i; v.pa = pa_i; v.cl = cl_i; v.s = s_i; v.t = t_i; v.eq = eq_i;
        v.eb = eb_i; v.ed = ed_i; v.ew = ew_i;
        tbl.push_back(v);
    endtask

    initial begin
        mreset();
`ifdef EVEN_COUNTER_CTRL_AUTO_RELOAD_EN
        add(1,0,0,  0,  4,  0,1,0,0);
        add(0,0,0,  0,  0,  2,1,0,0);
        add(0,0,0,  0,  0,  4,1,0,0);
        add(0,0,0,  0,  0,  0,1,1,0);
        add(0,0,0,  0,  0,  2,1,0,0);
        add(0,0,0,  0,  0,  4,1,0,0);
        add(0,0,0,  0,  0,  0,1,1,0);
        add(1,0,0, 40, 50,  2,1,0,0);
        add(0,0,1,  0,  0,  0,0,0,0);
`else
        add(1,0,0,  4, 10,  4,1,0,0);
        add(0,0,0,  0,  0,  6,1,0,0);
        add(0,0,0,  0,  0,  8,1,0,0);
        add(0,0,0,  0,  0, 10,1,0,0);
        add(0,0,0,  0,  0, 10,0,1,0);
        add(0,0,0,  0,  0, 10,0,1,0);
        add(1,0,0,250,  2,250,1,0,0);
        add(0,0,0,  0,  0,252,1,0,0);
        add(0,0,0,  0,  0,254,1,0,0);
        add(0,0,0,  0,  0,  0,1,0,1);
        add(0,0,0,  0,  0,  2,1,0,0);
        add(0,0,0,  0,  0,  2,0,1,0);
        add(1,0,0,  7, 13,  6,1,0,0);
        add(0,0,0,  0,  0,  8,1,0,0);
        add(0,1,0,  0,  0,  8,1,0,0);
        add(0,1,0,  0,  0,  8,1,0,0);
        add(0,0,0,  0,  0,  8,1,0,0);
        add(0,0,0,  0,  0, 10,1,0,0);
        add(0,0,0,  0,  0, 12,1,0,0);
        add(0,0,0,  0,  0, 12,0,1,0);
        add(1,0,0,  4,  5,  4,1,0,0);
        add(0,1,0,  0,  0,  4,0,1,0);
        add(1,0,0, 20, 30, 20,1,0,0);
        add(0,0,0,  0,  0, 22,1,0,0);
        add(1,0,0,100, 24, 24,1,0,0);
        add(0,0,0,  0,  0, 26,1,0,0);
        add(0,0,0,  0,  0, 28,1,0,0);
        add(0,0,0,  0,  0, 30,1,0,0);
        add(0,0,0,  0,  0, 30,0,1,0);
        add(1,0,0, 16, 40, 16,1,0,0);
        add(0,0,0,  0,  0, 18,1,0,0);
        add(0,0,0,  0,  0, 20,1,0,0);
        add(0,0,1,  0,  0,  0,0,0,0);
        add(0,0,0,  0,  0,  0,0,0,0);
        add(1,0,0,  2,  2,  2,1,0,0);
        add(0,0,0,  0,  0,  2,0,1,0);
        add(0,0,1,  0,  0,  0,0,0,0);
        add(1,0,1,  8,  8,  0,0,0,0);
        add(1,0,0,  8,  8,  8,1,0,0);
        add(0,0,0,  0,  0,  8,0,1,0);
`endif
        #12;
        chk("rst.q", q, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.wrap", wrap, 0);
        reset = 1'b1;
        foreach (tbl[i]) begin
            start = tbl[i].st; pause = tbl[i].pa; clear = tbl[i].cl;
            sv = tbl[i].s; tv = tbl[i].t;
            tick();
            chk($sformatf("v%0d.q", i), q, tbl[i].eq);
            chk($sformatf("v%0d.busy", i), busy, tbl[i].eb);
            chk($sformatf("v%0d.done", i), done, tbl[i].ed);
            chk($sformatf("v%0d.wrap", i), wrap, tbl[i].ew);
        end
        start = 0; pause = 0; clear = 1;
        tick();
        clear = 0; start = 1; sv = 30; tv = 100;
        tick();
        start = 0;
        repeat (5) tick();
        chk("midrun.q", q, 40);
        #2 reset = 1'b0;
        #1;
        chk("async.q", q, 0);
        chk("async.busy", busy, 0);
        chk("async.done", done, 0);
        mreset();
        #2 reset = 1'b1;
        tick();
        chk("idle.q", q, 0);
        chk("idle.busy", busy, 0);
        start = 1; sv = 2; tv = 6;
        tick();
        chk("restart.q", q, 2);
        chk("restart.busy", busy, 1);
        repeat (3000) begin
            start = ($urandom_range(0, 7) == 0);
            pause = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 40) == 0);
            sv = 8'($urandom);
            tv = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                             : 8'(sv + 2 * $urandom_range(0, 10) + $urandom_range(0, 1));
            tick();
            chk("rnd.q", q, mq);
            chk("rnd.busy", busy, mb);
            chk("rnd.done", done, md);
            chk("rnd.wrap", wrap, mw);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
